sb_tx_scheduler: RTL
====================

// Module: sb_tx_scheduler
// PURPOSE
//  Shares the sideband TX serializer and gated-clock controller among N_REQ packet sources (LTSM, RDI/FDI msgs, reg-access completions).
//  Grants one requester, feeds its 64b header (plus optional 64b data word) to the serializer, and drives the clock-controller enable.
//  Sequences each 64b word through the 64-active/32-idle window. Acks the source when the whole packet has left.
// PARAMETERS
//  N_REQ    3   number of packet sources (2..8)
//  WORD_W   64  sideband word width
// PORTS
//  i_pll_clk        in   1             sideband PLL clock (800 MHz); only clock
//  i_rst_n          in   1             asynchronous active-low reset
//  i_req            in   N_REQ         level; source has a packet; hold with payload until its o_ack
//  i_hdr            in   N_REQ*WORD_W  header word per source, [k*WORD_W +: WORD_W]
//  i_has_data       in   N_REQ         1 = packet carries a data word after the header
//  i_data           in   N_REQ*WORD_W  data word per source
//  o_ack            out  N_REQ         one-hot 1-cycle pulse: packet of that source fully sent
//  o_ser_load       out  1             1-cycle pulse: o_ser_word valid, serializer must capture
//  o_ser_word       out  WORD_W        word to serialize; stable from o_ser_load until i_ser_done
//  o_clk_en         out  1             to clock-controller enable; high while a word is serializing
//  i_ser_done       in   1             pulse from clock controller: 64 bits shifted
//  i_pack_finished  in   1             level from clock controller: high during 32-cycle idle gap
//  o_busy           out  1             high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, RR pointer = 0, latched words = 0.
//  FSM states: IDLE, LOAD_HDR, SEND_HDR, GAP_HDR, LOAD_DATA, SEND_DATA, GAP_DATA, ACK.
//  IDLE: if |i_req, grant one source (round-robin starting at pointer).
//    Latch its hdr, data and has_data into internal regs, then go to LOAD_HDR.
//    Later changes to i_* do not affect the packet in flight.
//  LOAD_HDR: o_ser_word=hdr, o_ser_load=1 for this cycle, then SEND_HDR.
//  SEND_HDR: o_clk_en=1. On i_ser_done: o_clk_en=0 next cycle, then GAP_HDR.
//  GAP_HDR: wait for i_pack_finished to go 1 and then 0 (falling edge, registered).
//    Then go to LOAD_DATA if has_data, else ACK.
//  LOAD_DATA/SEND_DATA/GAP_DATA: same as the header phase, with o_ser_word=data. Then ACK.
//  ACK: o_ack[grant]=1 for one cycle. RR pointer <= grant+1 (mod N_REQ). Go to IDLE.
//    A new arbitration can occur in the next IDLE cycle.
//  Latency: i_req rise in IDLE -> o_ser_load = 2 cycles.
//  Requests with no competitor re-grant the same source after ACK+IDLE.
//  i_req dropped mid-packet: ignored, packet completes, ack still issued.
//  Source must drop req the cycle after ack, or it is re-arbitrated.
//  i_ser_done outside SEND_*: ignored. i_pack_finished falling edge outside GAP_*: ignored.
//  Simultaneous requests: exactly one grant. RR fairness: no source waits more than N_REQ-1 packets.
//  Pointer wrap: grant N_REQ-1 -> pointer 0.
//  Reset asserted mid-packet: immediate return to reset state, no ack, o_clk_en drops asynchronously.
// CONFIGURATION
//  SB_TX_SCHED_PRIO_EN defined: source 0 (LTSM) has strict priority over all others at every arbitration.
//    Sources 1..N_REQ-1 round-robin among themselves; the pointer is not advanced by a grant to source 0.
//  Not defined: plain round-robin over all N_REQ sources.
// STRUCTURE
//  Package sb_tx_pkg: SB_WORD_W=64, typedef enum logic[2:0] sb_tx_sched_state_t, SB_ACTIVE_CYC=64, SB_GAP_CYC=32.
//  Sub-module sb_rr_arbiter #(N): inputs req, ptr; output one-hot gnt (combinational).
//    The scheduler owns the pointer register.
//  Clock gating stays in the clock controller; this block generates no clocks.
// TESTING
//  Bench models the clock controller: i_ser_done 64 cycles after o_clk_en rises;
//    i_pack_finished high for cycles 65..96.
//  1. Single req src1, hdr=64'hA5A5_0000_1234_5678, has_data=0:
//     one o_ser_load with that word, o_clk_en high 64 cycles, o_ack=3'b010 after gap, o_busy low next cycle.
//  2. src2 with has_data=1, data=64'hDEAD_BEEF_0000_0001:
//     two loads, hdr then data; gap between words; single ack after second gap.
//  3. i_req=3'b111 held continuously, no PRIO:
//     ack order 0,1,2,0,1,2; never two acks in one cycle.
//  4. With SB_TX_SCHED_PRIO_EN, i_req=3'b111 held:
//     ack order 0,0,0...; with src0 dropped after 2 acks, order then 1,2,1,2.
//  5. Reset pulsed during SEND_DATA:
//     all outputs 0 at once, no ack; after release, same request replays from header.
//  6. i_hdr of src0 changed and i_req dropped mid-SEND_HDR:
//     o_ser_word unchanged, packet completes, ack still pulses.

Source files
------------

// File: rtl/sb_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sb_tx_pkg
//   Shared types and constants for the sideband TX scheduler.
//   SB_WORD_W     : sideband word width
//   SB_ACTIVE_CYC : clock-controller active window per word (bits shifted)
//   SB_GAP_CYC    : clock-controller idle gap after each word
//   sb_tx_sched_state_t : scheduler FSM encoding (also exported for debug)
//   sb_oh2idx     : one-hot (up to 8 bits) to binary index
// ---------------------------------------------------------------------------
package sb_tx_pkg;

  localparam int SB_WORD_W     = 64;
  localparam int SB_ACTIVE_CYC = 64;
  localparam int SB_GAP_CYC    = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_HDR  = 3'd1,
    ST_SEND_HDR  = 3'd2,
    ST_GAP_HDR   = 3'd3,
    ST_LOAD_DATA = 3'd4,
    ST_SEND_DATA = 3'd5,
    ST_GAP_DATA  = 3'd6,
    ST_ACK       = 3'd7
  } sb_tx_sched_state_t;

  function automatic logic [2:0] sb_oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (oh[k]) idx = idx | 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sb_tx_scheduler_arbiter.sv
// ---------------------------------------------------------------------------
// sb_rr_arbiter
//   Combinational round-robin arbiter. Searches req_i starting at index ptr_i
//   and wrapping; grants the first requester found. The pointer register
//   lives in the caller.
//   req_i [N-1:0]          : request vector
//   ptr_i [$clog2(N)-1:0]  : index with highest priority this cycle
//   gnt_o [N-1:0]          : one-hot grant, all-zero when no request
// ---------------------------------------------------------------------------
module sb_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_tx_scheduler.sv
// ---------------------------------------------------------------------------
// sb_tx_scheduler
//   Shares the sideband TX serializer / gated-clock controller among N_REQ
//   packet sources. One source is granted, its header (and optional data
//   word) is latched, each word is handed to the serializer and walked
//   through the active window and idle gap, then the source is acked.
//
//   Handshake: i_req is a level held with its payload until the one-cycle
//   o_ack pulse for that source; the payload is latched at grant so later
//   changes to any i_* input do not affect the packet in flight. o_ser_load
//   pulses once per word; o_ser_word is stable from that pulse until
//   i_ser_done. o_clk_en is high exactly while the scheduler waits for
//   i_ser_done.
//
//   Ports: i_pll_clk, i_rst_n (async active-low), i_req, i_hdr, i_has_data,
//   i_data, o_ack, o_ser_load, o_ser_word, o_clk_en, i_ser_done,
//   i_pack_finished, o_busy, o_dbg_state (FSM state for observation).
//
//   Build option SB_TX_SCHED_PRIO_EN: source 0 wins every arbitration;
//   sources 1..N_REQ-1 round-robin among themselves and a grant to source 0
//   leaves the pointer alone. Undefined: plain round-robin over all sources.
// ---------------------------------------------------------------------------
module sb_tx_scheduler
  import sb_tx_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int WORD_W = SB_WORD_W
) (
  input  logic                    i_pll_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*WORD_W-1:0] i_hdr,
  input  logic [N_REQ-1:0]        i_has_data,
  input  logic [N_REQ*WORD_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_ser_load,
  output logic [WORD_W-1:0]       o_ser_word,
  output logic                    o_clk_en,
  input  logic                    i_ser_done,
  input  logic                    i_pack_finished,
  output logic                    o_busy,
  output logic [2:0]              o_dbg_state
);

  localparam int PTR_W = $clog2(N_REQ);

  sb_tx_sched_state_t state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_nxt;
  logic [N_REQ-1:0]   gnt_q, arb_req, rr_gnt, arb_gnt;
  logic [WORD_W-1:0]  hdr_q, data_q, ser_word_q, sel_hdr, sel_data;
  logic               has_data_q, sel_hd, ser_load_q, pf_q, pf_fall, start;
  logic [2:0]         gidx;

`ifdef SB_TX_SCHED_PRIO_EN
  // Source 0 is taken out of the round-robin and overrides it.
  assign arb_req = {i_req[N_REQ-1:1], 1'b0};
  assign arb_gnt = i_req[0] ? N_REQ'(1) : rr_gnt;
`else
  assign arb_req = i_req;
  assign arb_gnt = rr_gnt;
`endif

  sb_rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  always_comb begin
    sel_hdr  = '0;
    sel_data = '0;
    sel_hd   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_hdr  = i_hdr[k*WORD_W +: WORD_W];
        sel_data = i_data[k*WORD_W +: WORD_W];
        sel_hd   = i_has_data[k];
      end
    end
  end

  // Pointer moves to the source after the one just served, wrapping to 0.
  assign gidx = sb_oh2idx(8'(gnt_q));
  always_comb begin
    ptr_nxt = '0;
    if (int'(gidx) < N_REQ-1) ptr_nxt = PTR_W'(gidx + 3'd1);
  end

  // Registered falling edge of the idle-gap indicator marks end of a word.
  assign pf_fall = pf_q & ~i_pack_finished;
  assign start   = (state_q == ST_IDLE) && (|i_req);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (|i_req) state_d = ST_LOAD_HDR;
      ST_LOAD_HDR:  state_d = ST_SEND_HDR;
      ST_SEND_HDR:  if (i_ser_done) state_d = ST_GAP_HDR;
      ST_GAP_HDR:   if (pf_fall) state_d = has_data_q ? ST_LOAD_DATA : ST_ACK;
      ST_LOAD_DATA: state_d = ST_SEND_DATA;
      ST_SEND_DATA: if (i_ser_done) state_d = ST_GAP_DATA;
      ST_GAP_DATA:  if (pf_fall) state_d = ST_ACK;
      ST_ACK:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
      ser_word_q <= '0;
      ser_load_q <= 1'b0;
      pf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pf_q       <= i_pack_finished;
      ser_load_q <= (state_q == ST_LOAD_HDR) || (state_q == ST_LOAD_DATA);
      if (start) begin
        gnt_q      <= arb_gnt;
        hdr_q      <= sel_hdr;
        data_q     <= sel_data;
        has_data_q <= sel_hd;
      end
      if (state_q == ST_LOAD_HDR)  ser_word_q <= hdr_q;
      if (state_q == ST_LOAD_DATA) ser_word_q <= data_q;
`ifdef SB_TX_SCHED_PRIO_EN
      if (state_q == ST_ACK && !gnt_q[0]) ptr_q <= ptr_nxt;
`else
      if (state_q == ST_ACK) ptr_q <= ptr_nxt;
`endif
    end
  end

  assign o_ser_load  = ser_load_q;
  assign o_ser_word  = ser_word_q;
  assign o_clk_en    = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA);
  assign o_ack       = (state_q == ST_ACK) ? gnt_q : '0;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule
